// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the cascaded up/down modulo counter.
package updown_mod_counter_pkg;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int unsigned CALC_W = 32;

    // Limit a raw digit value to the legal range 0..modulus-1.
    function automatic logic [CALC_W-1:0] clamp_digit(input logic [CALC_W-1:0] value,
                                                      input int unsigned       modulus);
        if (value >= CALC_W'(modulus)) begin
            return CALC_W'(modulus - 1);
        end
        return value;
    endfunction

    // Terminal state depends only on the current direction.
    function automatic logic is_terminal(input logic all_max,
                                         input logic all_zero,
                                         input logic dir);
        return (dir == DIR_DN) ? all_zero : all_max;
    endfunction

endpackage

// File: rtl/updown_mod_counter_mod_digit.sv
// One modulo digit: clear, clamped load, and carry/borrow-driven step.
module mod_digit #(
    parameter int unsigned    DW      = 4,
    parameter int unsigned    MODULUS = 10,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] ld_val,
    input  logic          step,
    input  logic          dir,
    output logic [DW-1:0] q,
    output logic          at_max,
    output logic          at_zero
);
    import updown_mod_counter_pkg::*;

    localparam logic [DW-1:0] TOP = DW'(MODULUS - 1);

    logic [DW-1:0] q_nxt_c;

    assign at_max  = (q == TOP);
    assign at_zero = (q == '0);

    // Next digit value, clr > load > step.
    always_comb begin
        q_nxt_c = q;
        if (clr) begin
            q_nxt_c = '0;
        end else if (load) begin
            q_nxt_c = DW'(clamp_digit(CALC_W'(ld_val), MODULUS));
        end else if (step) begin
            if (dir == DIR_UP) begin
                q_nxt_c = at_max ? '0 : q + DW'(1);
            end else begin
                q_nxt_c = at_zero ? TOP : q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= q_nxt_c;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Multi-digit up/down modulo counter with clear, clamped load, wrap/saturate
// mode, combinational terminal count and a registered wrap pulse.
module updown_mod_counter #(
    parameter int unsigned               DIGITS  = 2,
    parameter int unsigned               DW      = 4,
    parameter int unsigned               MODULUS = 10,
    parameter logic [DIGITS*DW-1:0]      RST_VAL = '0,
    parameter bit                        WRAP    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    input  logic                 en,
    input  logic                 dir,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc,
    output logic                 wrap_p
);
    import updown_mod_counter_pkg::*;

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS-1:0] step;
    logic              hold_c;
    logic              wrap_nxt_c;

    assign tc     = is_terminal(&at_max, &at_zero, dir);
    assign hold_c = !WRAP && tc;

    // Ripple carry/borrow: a digit steps only when every lower digit rolls over.
    always_comb begin
        step    = '0;
        step[0] = en && !hold_c;
        for (int i = 1; i < int'(DIGITS); i++) begin
            step[i] = step[i-1] && ((dir == DIR_DN) ? at_zero[i-1] : at_max[i-1]);
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        mod_digit #(
            .DW      (DW),
            .MODULUS (MODULUS),
            .RST_VAL (RST_VAL[g*DW +: DW])
        ) u_digit (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .load    (load),
            .ld_val  (load_val[g*DW +: DW]),
            .step    (step[g]),
            .dir     (dir),
            .q       (count[g*DW +: DW]),
            .at_max  (at_max[g]),
            .at_zero (at_zero[g])
        );

        if (32'(RST_VAL[g*DW +: DW]) >= MODULUS) begin : g_bad_rst_val
            $error("updown_mod_counter: RST_VAL digit %0d out of range", g);
        end
    end

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("updown_mod_counter: DIGITS must be 1..8");
    end

    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << DW)) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must be 2..2**DW");
    end

    assign wrap_nxt_c = WRAP && en && tc && !clr && !load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_p <= 1'b0;
        end else begin
            wrap_p <= wrap_nxt_c;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three configurations share stimulus and are
// compared with an integer-valued reference model plus directed constants.
module tb_updown_mod_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b0;
    logic [11:0] lv = '0;

    logic [7:0]  c0, c1;
    logic [11:0] c2;
    logic        tc0, tc1, tc2;
    logic        w0, w1, w2;

    int total = 0;
    int bad = 0;

    // Model state: counter value as a plain integer 0..MODULUS**DIGITS-1.
    int m0, m1, m2;
    bit mw0, mw1, mw2;

    always #5 clk = ~clk;

    updown_mod_counter #(.DIGITS(2), .DW(4), .MODULUS(10), .RST_VAL(8'h03), .WRAP(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv[7:0]),
        .en(en), .dir(dir), .count(c0), .tc(tc0), .wrap_p(w0));

    updown_mod_counter #(.DIGITS(2), .DW(4), .MODULUS(10), .RST_VAL(8'h00), .WRAP(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv[7:0]),
        .en(en), .dir(dir), .count(c1), .tc(tc1), .wrap_p(w1));

    updown_mod_counter #(.DIGITS(3), .DW(4), .MODULUS(16), .RST_VAL(12'h000), .WRAP(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv),
        .en(en), .dir(dir), .count(c2), .tc(tc2), .wrap_p(w2));

    function automatic int pw(int m, int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * m;
        return r;
    endfunction

    function automatic int ld_int(logic [31:0] p, int d, int dw, int m);
        int r = 0;
        int x;
        for (int i = d - 1; i >= 0; i--) begin
            x = int'((p >> (i * dw)) & ((32'd1 << dw) - 32'd1));
            if (x >= m) x = m - 1;
            r = r * m + x;
        end
        return r;
    endfunction

    function automatic logic [31:0] enc(int v, int d, int dw, int m);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r = r | (32'(v % m) << (i * dw));
            v = v / m;
        end
        return r;
    endfunction

    function automatic int nxt(int v, int d, int dw, int m, bit wrap,
                               bit c, bit l, bit e, bit dr, logic [31:0] p);
        int top = pw(m, d) - 1;
        if (c) return 0;
        if (l) return ld_int(p, d, dw, m);
        if (!e) return v;
        if (!dr) return (v == top) ? (wrap ? 0 : v) : v + 1;
        return (v == 0) ? (wrap ? top : 0) : v - 1;
    endfunction

    function automatic bit wrp(int v, int d, int m, bit wrap, bit c, bit l, bit e, bit dr);
        int top = pw(m, d) - 1;
        return !c && !l && e && wrap && (dr ? (v == 0) : (v == top));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= 3; m1 <= 0; m2 <= 0;
            mw0 <= 1'b0; mw1 <= 1'b0; mw2 <= 1'b0;
        end else begin
            m0  <= nxt(m0, 2, 4, 10, 1'b1, clr, load, en, dir, 32'(lv));
            m1  <= nxt(m1, 2, 4, 10, 1'b0, clr, load, en, dir, 32'(lv));
            m2  <= nxt(m2, 3, 4, 16, 1'b1, clr, load, en, dir, 32'(lv));
            mw0 <= wrp(m0, 2, 10, 1'b1, clr, load, en, dir);
            mw1 <= wrp(m1, 2, 10, 1'b0, clr, load, en, dir);
            mw2 <= wrp(m2, 3, 16, 1'b1, clr, load, en, dir);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        load = 1'b1; lv = 12'h055; dir = 1'b0; en = 1'b0; clr = 1'b0;
        tick();
        load = 1'b0;
        total++;
        if (c0 !== 8'h55) begin bad++; $display("FAIL pre_reset_load count=%h exp=55", c0); end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (c0 !== 8'h03) begin bad++; $display("FAIL async_reset_count count=%h exp=03", c0); end
        total++;
        if (w0 !== 1'b0 || tc0 !== 1'b0) begin
            bad++; $display("FAIL async_reset_flags wrap_p=%b tc=%b exp=0/0", w0, tc0);
        end
        total++;
        if (c1 !== 8'h00 || c2 !== 12'h000) begin
            bad++; $display("FAIL async_reset_other c1=%h c2=%h exp=00/000", c1, c2);
        end
        #2 rst_n = 1'b1;
        tick();
        total++;
        if (c0 !== 8'h03) begin bad++; $display("FAIL reset_hold count=%h exp=03", c0); end
        en = 1'b1;
        tick();
        en = 1'b0;
        total++;
        if (c0 !== 8'h04) begin bad++; $display("FAIL resume_from_rst count=%h exp=04", c0); end
    endtask

    task automatic test_up_wrap();
        logic [7:0] ec [3] = '{8'h98, 8'h99, 8'h00};
        bit         et [3] = '{1'b0, 1'b1, 1'b0};
        bit         ew [3] = '{1'b0, 1'b0, 1'b1};
        load = 1'b1; lv = 12'h097; dir = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (c0 !== ec[i] || tc0 !== et[i] || w0 !== ew[i]) begin
                bad++;
                $display("FAIL up_wrap step%0d count=%h tc=%b wrap_p=%b exp=%h/%b/%b",
                         i, c0, tc0, w0, ec[i], et[i], ew[i]);
            end
            total++;
            if (c0[3:0] > 4'd9 || c0[7:4] > 4'd9) begin
                bad++; $display("FAIL up_digit_range count=%h exp=bcd", c0);
            end
        end
        en = 1'b0;
        tick();
        total++;
        if (c0 !== 8'h00 || w0 !== 1'b0) begin
            bad++; $display("FAIL up_wrap_pulse_len count=%h wrap_p=%b exp=00/0", c0, w0);
        end
    endtask

    task automatic test_down_wrap();
        logic [7:0] ec [3] = '{8'h00, 8'h99, 8'h98};
        bit         et [3] = '{1'b1, 1'b0, 1'b0};
        bit         ew [3] = '{1'b0, 1'b1, 1'b0};
        load = 1'b1; lv = 12'h001; dir = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (c0 !== ec[i] || tc0 !== et[i] || w0 !== ew[i]) begin
                bad++;
                $display("FAIL down_wrap step%0d count=%h tc=%b wrap_p=%b exp=%h/%b/%b",
                         i, c0, tc0, w0, ec[i], et[i], ew[i]);
            end
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_load_clr();
        load = 1'b1; lv = 12'h0AF;
        tick();
        total++;
        if (c0 !== 8'h99 || w0 !== 1'b0) begin
            bad++; $display("FAIL load_clamp count=%h wrap_p=%b exp=99/0", c0, w0);
        end
        clr = 1'b1; lv = 12'h055;
        tick();
        total++;
        if (c0 !== 8'h00) begin bad++; $display("FAIL clr_over_load count=%h exp=00", c0); end
        clr = 1'b0;
        tick();
        total++;
        if (c0 !== 8'h55) begin bad++; $display("FAIL load_after_clr count=%h exp=55", c0); end
        clr = 1'b1; en = 1'b1; lv = 12'h077;
        tick();
        clr = 1'b0; load = 1'b0; en = 1'b0;
        total++;
        if (c0 !== 8'h00 || w0 !== 1'b0) begin
            bad++; $display("FAIL clr_load_en count=%h wrap_p=%b exp=00/0", c0, w0);
        end
    endtask

    task automatic test_saturate();
        load = 1'b1; lv = 12'h098; dir = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (c1 !== 8'h99 || w1 !== 1'b0 || tc1 !== 1'b1) begin
                bad++;
                $display("FAIL saturate step%0d count=%h wrap_p=%b tc=%b exp=99/0/1",
                         i, c1, w1, tc1);
            end
        end
        dir = 1'b1;
        tick();
        en = 1'b0;
        total++;
        if (c1 !== 8'h98) begin bad++; $display("FAIL saturate_reverse count=%h exp=98", c1); end
    endtask

    task automatic test_hold_dir();
        logic [7:0] vals [3] = '{8'h99, 8'h00, 8'h45};
        bit exp_tc;
        for (int v = 0; v < 3; v++) begin
            load = 1'b1; lv = 12'(vals[v]); en = 1'b0;
            tick();
            load = 1'b0;
            for (int i = 0; i < 5; i++) begin
                dir = (i % 2 == 1);
                #1;
                exp_tc = (vals[v] == 8'h99 && !dir) || (vals[v] == 8'h00 && dir);
                total++;
                if (tc0 !== exp_tc) begin
                    bad++; $display("FAIL hold_tc val=%h dir=%b tc=%b exp=%b", vals[v], dir, tc0, exp_tc);
                end
                tick();
                total++;
                if (c0 !== vals[v]) begin
                    bad++; $display("FAIL hold_count count=%h exp=%h", c0, vals[v]);
                end
            end
        end
        dir = 1'b0;
    endtask

    task automatic test_hex();
        load = 1'b1; lv = 12'hFFE; dir = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        total++;
        if (c2 !== 12'hFFF || tc2 !== 1'b1 || w2 !== 1'b0) begin
            bad++; $display("FAIL hex_top count=%h tc=%b wrap_p=%b exp=FFF/1/0", c2, tc2, w2);
        end
        tick();
        en = 1'b0;
        total++;
        if (c2 !== 12'h000 || w2 !== 1'b1) begin
            bad++; $display("FAIL hex_wrap count=%h wrap_p=%b exp=000/1", c2, w2);
        end
    endtask

    task automatic test_random();
        logic [31:0] e0, e1, e2;
        for (int n = 0; n < 600; n++) begin
            clr  = ($urandom % 40 == 0);
            load = ($urandom % 10 == 0);
            en   = ($urandom % 4 != 0);
            if ($urandom % 12 == 0) dir = ~dir;
            lv   = 12'($urandom);
            tick();
            e0 = enc(m0, 2, 4, 10);
            e1 = enc(m1, 2, 4, 10);
            e2 = enc(m2, 3, 4, 16);
            total++;
            if (c0 !== e0[7:0] || w0 !== mw0 || tc0 !== (dir ? (m0 == 0) : (m0 == 99))) begin
                bad++; $display("FAIL rand_u0 n=%0d count=%h wrap_p=%b tc=%b exp=%h/%b", n, c0, w0, tc0, e0[7:0], mw0);
            end
            total++;
            if (c1 !== e1[7:0] || w1 !== mw1 || tc1 !== (dir ? (m1 == 0) : (m1 == 99))) begin
                bad++; $display("FAIL rand_u1 n=%0d count=%h wrap_p=%b tc=%b exp=%h/%b", n, c1, w1, tc1, e1[7:0], mw1);
            end
            total++;
            if (c2 !== e2[11:0] || w2 !== mw2 || tc2 !== (dir ? (m2 == 0) : (m2 == 4095))) begin
                bad++; $display("FAIL rand_u2 n=%0d count=%h wrap_p=%b tc=%b exp=%h/%b", n, c2, w2, tc2, e2[11:0], mw2);
            end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        tick();
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clr();
        test_saturate();
        test_hold_dir();
        test_hex();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
